// File: rtl/sq_image_cache_reader.sv
// sq_image_cache_reader: raster-order read-out of the square image cache into a valid/ready stream
// Ports: clk/reset (sync, active high); start pulse begins a frame, busy/done report progress;
// re/raddrX/raddrY drive the cache read port and rdata returns RD_LATENCY cycles after re;
// q/q_valid/q_ready form the output stream, q_eol marks the row end, q_last marks the frame end.
module sq_image_cache_reader #(
    parameter int WORD_SIZE  = 8,
    parameter int COLS       = 32,
    parameter int ROWS       = 32,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 5,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 re,
    output logic [X_WIDTH-1:0]   raddrX,
    output logic [Y_WIDTH-1:0]   raddrY,
    input  logic [WORD_SIZE-1:0] rdata,
    output logic [WORD_SIZE-1:0] q,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic                 q_eol,
    output logic                 q_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(RD_LATENCY + FIFO_DEPTH + 2) + 1;
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(COLS - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(ROWS - 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [X_WIDTH-1:0] x_q, x_d, raddr_x_q, raddr_x_d;
    logic [Y_WIDTH-1:0] y_q, y_d, raddr_y_q, raddr_y_d;
    logic re_q, re_d;
    logic [RD_LATENCY-1:0] pv_q, pv_d, pe_q, pe_d, pl_q, pl_d;
    logic [WORD_SIZE+1:0] mem_q [FIFO_DEPTH];
    logic [WORD_SIZE+1:0] head;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [CW-1:0] inflight, used;
    logic push, pop, credit, issue, at_eol, at_last;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            re_q      <= 1'b0;
            raddr_x_q <= '0;
            raddr_y_q <= '0;
            pv_q      <= '0;
            pe_q      <= '0;
            pl_q      <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            re_q      <= re_d;
            raddr_x_q <= raddr_x_d;
            raddr_y_q <= raddr_y_d;
            pv_q      <= pv_d;
            pe_q      <= pe_d;
            pl_q      <= pl_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {pl_q[RD_LATENCY-1], pe_q[RD_LATENCY-1], rdata};
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (credit && at_last) state_d = DRAIN;
            DRAIN:   if (pop && q_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // Credit counts the read being presented now, reads still in the latency pipe and
    // buffered words; a pop this cycle frees a slot so a full-rate stream never stalls.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pv_q[i]);
        used      = inflight + CW'(re_q) + CW'(cnt_q) - CW'(pop);
        credit    = used < CW'(FIFO_DEPTH);
        at_eol    = x_q == X_LAST;
        at_last   = at_eol && y_q == Y_LAST;
        issue     = state_q == ISSUE && credit;
        re_d      = issue;
        raddr_x_d = issue ? x_q : raddr_x_q;
        raddr_y_d = issue ? y_q : raddr_y_q;
        x_d       = state_q == IDLE ? '0 : issue ? (at_eol ? '0 : x_q + 1'b1) : x_q;
        y_d       = state_q == IDLE ? '0 : (issue && at_eol) ? (at_last ? '0 : y_q + 1'b1) : y_q;
        busy      = state_q == ISSUE || state_q == DRAIN;
        done      = state_q == DONE;
        re        = re_q;
        raddrX    = raddr_x_q;
        raddrY    = raddr_y_q;
    end
    // Flags ride along with the valid bit so they emerge exactly with their rdata.
    always_comb begin
        pv_d    = RD_LATENCY'({pv_q, re_q});
        pe_d    = RD_LATENCY'({pe_q, raddr_x_q == X_LAST});
        pl_d    = RD_LATENCY'({pl_q, raddr_x_q == X_LAST && raddr_y_q == Y_LAST});
        push    = pv_q[RD_LATENCY-1];
        q_valid = cnt_q != '0;
        pop     = q_valid && q_ready;
        wp_d    = wp_q + AW'(push);
        rp_d    = rp_q + AW'(pop);
        cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        head    = mem_q[rp_q];
        q       = head[WORD_SIZE-1:0];
        q_eol   = q_valid && head[WORD_SIZE];
        q_last  = q_valid && head[WORD_SIZE+1];
    end
    assert property (@(posedge clk) disable iff (reset) !(push && !pop && cnt_q == (AW+1)'(FIFO_DEPTH)));
endmodule

// File: tb/tb_sq_image_cache_reader.sv
module tb_sq_image_cache_reader;
    localparam int W = 8, L = 2, D = 4, XW = 5, YW = 5;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, qr = 1'b0, sel = 1'b0;
    always #5 clk = ~clk;
    logic busy_a, done_a, re_a, qv_a, eol_a, last_a, busy_b, done_b, re_b, qv_b, eol_b, last_b;
    logic [XW-1:0] rx_a, rx_b;
    logic [YW-1:0] ry_a, ry_b;
    logic [W-1:0] rd_a, rd_b, q_a, q_b, junk;
    sq_image_cache_reader #(.WORD_SIZE(W), .COLS(4), .ROWS(4), .X_WIDTH(XW), .Y_WIDTH(YW),
        .RD_LATENCY(L), .FIFO_DEPTH(D)) dut_a (
        .clk(clk), .reset(rst), .start(start && !sel), .busy(busy_a), .done(done_a), .re(re_a),
        .raddrX(rx_a), .raddrY(ry_a), .rdata(rd_a), .q(q_a), .q_valid(qv_a), .q_ready(qr),
        .q_eol(eol_a), .q_last(last_a));
    sq_image_cache_reader #(.WORD_SIZE(W), .COLS(1), .ROWS(3), .X_WIDTH(XW), .Y_WIDTH(YW),
        .RD_LATENCY(L), .FIFO_DEPTH(D)) dut_b (
        .clk(clk), .reset(rst), .start(start && sel), .busy(busy_b), .done(done_b), .re(re_b),
        .raddrX(rx_b), .raddrY(ry_b), .rdata(rd_b), .q(q_b), .q_valid(qv_b), .q_ready(qr),
        .q_eol(eol_b), .q_last(last_b));
    typedef struct packed {logic v; logic [XW-1:0] x; logic [YW-1:0] y;} req_t;
    req_t ha [L];
    req_t hb [L];
    always @(posedge clk) begin
        junk  <= W'($urandom);
        ha[0] <= '{re_a, rx_a, ry_a};
        hb[0] <= '{re_b, rx_b, ry_b};
        for (int i = 1; i < L; i++) begin
            ha[i] <= ha[i-1];
            hb[i] <= hb[i-1];
        end
    end
    assign rd_a = ha[L-1].v ? W'(ha[L-1].x + 16 * ha[L-1].y) : junk;
    assign rd_b = hb[L-1].v ? W'(hb[L-1].x + 16 * hb[L-1].y) : junk;
    logic m_busy, m_done, m_re, m_qv, m_eol, m_last;
    logic [W-1:0] m_q;
    logic [15:0] m_pack;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_re   = sel ? re_b : re_a;
    assign m_qv   = sel ? qv_b : qv_a;
    assign m_eol  = sel ? eol_b : eol_a;
    assign m_last = sel ? last_b : last_a;
    assign m_q    = sel ? q_b : q_a;
    assign m_pack = sel ? {busy_b, done_b, re_b, rx_b, ry_b, qv_b, eol_b, last_b}
                        : {busy_a, done_a, re_a, rx_a, ry_a, qv_a, eol_a, last_a};
    typedef struct {int sel; int mode; int stall; int poke; int abort; int exp_cyc; int exp_first;} vec_t;
    vec_t vecs [8];
    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic run_frame(input vec_t v);
        logic [9:0] exp_q [$];
        logic [9:0] got, pword;
        logic pstall;
        int cols, rows, first, done_cyc, re_stall, popped;
        cols = v.sel != 0 ? 1 : 4;
        rows = v.sel != 0 ? 3 : 4;
        exp_q = {};
        for (int y = 0; y < rows; y++)
            for (int x = 0; x < cols; x++)
                exp_q.push_back({y == rows - 1 && x == cols - 1, x == cols - 1, 8'(x + 16 * y)});
        sel = v.sel[0];
        start = 1'b1;
        first = -1; done_cyc = -1; re_stall = 0; popped = 0; pstall = 1'b0; pword = '0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (v.abort > 0 && popped == v.abort) begin
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                chk("abort_reset_state", m_pack, 0);
                rst = 1'b0;
                repeat (L + 4) begin
                    @(negedge clk);
                    chk("no_stale_after_reset", {m_qv, m_busy}, 0);
                end
                return;
            end
            start = v.poke != 0 && cyc == 3;
            qr = (cyc <= v.stall) ? 1'b0 : (v.mode == 0) ? 1'b1 : (v.mode == 1) ? cyc[0]
                 : 1'($urandom_range(0, 1));
            if (cyc == 1) chk("busy_after_start", m_busy, 1);
            if (cyc <= v.stall && m_re) re_stall++;
            if (m_qv && first < 0) first = cyc;
            got = {m_last, m_eol, m_q};
            if (pstall && m_qv) chk("hold_while_stalled", got, pword);
            if (m_qv && qr) begin
                if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
                else begin
                    chk("word", got, exp_q.pop_front());
                    popped++;
                end
            end
            pstall = m_qv && !qr;
            pword = got;
            if (m_done) begin
                done_cyc = cyc;
                break;
            end
        end
        chk("done_seen", done_cyc > 0, 1);
        if (v.exp_cyc > 0) chk("start_to_done", done_cyc, v.exp_cyc);
        if (v.exp_first > 0) chk("first_valid_cycle", first, v.exp_first);
        if (v.stall > 0) chk("stall_re_bound", re_stall <= D, 1);
        chk("words_left", exp_q.size(), 0);
        start = v.poke != 0;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle_idle", {m_done, m_busy}, 0);
    endtask
    initial begin
        vec_t r;
        vecs[0] = '{0, 0, 0,  0, 0, 16 + L + 3, L + 3};
        vecs[1] = '{0, 1, 0,  0, 0, -1, -1};
        vecs[2] = '{0, 0, 20, 0, 0, -1, -1};
        vecs[3] = '{0, 0, 0,  1, 0, 16 + L + 3, L + 3};
        vecs[4] = '{0, 0, 0,  0, 7, -1, -1};
        vecs[5] = '{0, 0, 0,  0, 0, 16 + L + 3, L + 3};
        vecs[6] = '{1, 0, 0,  0, 0, 3 + L + 3, L + 3};
        vecs[7] = '{1, 1, 0,  0, 0, -1, -1};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state_a", {busy_a, done_a, re_a, rx_a, ry_a, qv_a, eol_a, last_a}, 0);
        chk("reset_state_b", {busy_b, done_b, re_b, rx_b, ry_b, qv_b, eol_b, last_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_frame(vecs[i]);
        for (int i = 0; i < 8; i++) begin
            r = '{int'($urandom_range(0, 1)), 2, int'($urandom_range(0, 8)), 0, 0, -1, -1};
            run_frame(r);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sq_image_cache_reader.md
Name: sq_image_cache_reader

Overview:
Read-side counterpart of the square image cache loader. On a start pulse it scans the 2D image cache in raster order (X fastest), issues read addresses, and captures the fixed-latency read data. It streams the words out on a valid/ready port with end-of-row and end-of-frame flags. A credit-limited prefetch FIFO absorbs read latency and downstream backpressure.

Parameters:
WORD_SIZE, 8, bits per cache word
COLS, 32, words per row (X extent), >=1
ROWS, 32, rows per frame (Y extent), >=1
X_WIDTH, 5, width of raddrX, >= clog2(COLS)
Y_WIDTH, 5, width of raddrY, >= clog2(ROWS)
RD_LATENCY, 2, cycles from re to valid rdata, >=1
FIFO_DEPTH, 4, output buffer entries, power of 2, >= RD_LATENCY+1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begin a frame readout
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last word has been accepted downstream
re  out  1  cache read enable
raddrX  out  X_WIDTH  cache read column
raddrY  out  Y_WIDTH  cache read row
rdata  in  WORD_SIZE  cache read data, valid RD_LATENCY cycles after re
q  out  WORD_SIZE  stream data
q_valid  out  1  stream data valid
q_ready  in  1  downstream accepts when q_valid and q_ready are both high
q_eol  out  1  q is the last word of a row (X == COLS-1)
q_last  out  1  q is the last word of the frame (implies q_eol)

Behaviour:
- Reset: state IDLE. busy=0, done=0, re=0, raddrX=0, raddrY=0, q_valid=0, q_eol=0, q_last=0. FIFO is emptied and the in-flight pipeline is cleared. Reset mid-frame abandons the frame, and any read data returning afterwards is discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> ISSUE, with X=Y=0 and busy=1 on the next cycle. start is ignored in all other states.
- ISSUE: re=1 in a cycle only when credit is available, where credit means inflight + fifo_count < FIFO_DEPTH. inflight is the number of reads issued whose data has not yet returned.
  - raddrX/raddrY are registered outputs that present the current coordinate alongside re.
  - After each issued read, X increments. At X==COLS-1, X wraps to 0 and Y increments.
  - Issuing coordinate (COLS-1, ROWS-1) -> DRAIN. No read is issued past the last coordinate.
- Read return: an RD_LATENCY-deep valid shift register tags each read with its eol/last flags. When the tag emerges, rdata and the flags are written into the FIFO.
  - Credit accounting guarantees the FIFO never overflows. An overflow is a design error, covered by an assertion.
- Output: q/q_eol/q_last/q_valid come from the FIFO head (first-word fall-through).
  - q_valid=1 whenever the FIFO is non-empty.
  - A pop occurs on q_valid & q_ready. q holds stable while q_valid=1 and q_ready=0.
  - A push and a pop in the same cycle leave the count unchanged. A push into an empty FIFO shows q_valid on the next cycle.
- DRAIN: no reads are issued. When the word with q_last is popped -> DONE.
- DONE: done=1 for one cycle, busy=0 from this cycle, then -> IDLE. A start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
- Throughput: with q_ready held at 1, one word per cycle sustained.
  - First q_valid appears RD_LATENCY+1 cycles after the first re.
  - Total frame time is COLS*ROWS + RD_LATENCY + 3 cycles from start to done (±1 is not permitted; bench checks exactly).
- Counters: X counts 0..COLS-1 and Y counts 0..ROWS-1. COLS=1 or ROWS=1 must work: every word has q_eol=1 when COLS=1.

Test Plan:
- Reset, then start with COLS=ROWS=4 and q_ready=1 -> 16 words in raster order; q_eol on words 3,7,11,15; q_last on word 15 only; done once; start-to-done = 16+RD_LATENCY+3 cycles.
- Cache model returns data = {Y,X}; q_ready toggles every other cycle -> data sequence is exact, with no drops or duplicates; q is stable while stalled.
- q_ready held at 0 for 20 cycles after start -> re is asserted at most FIFO_DEPTH times, with no overflow; on releasing q_ready all 16 words emerge in order.
- Start pulsed again during busy and in the DONE cycle -> both ignored; a start one cycle after done begins a new frame from (0,0).
- Reset asserted mid-frame (after 7 words popped) with reads in flight -> all outputs return to reset values the next cycle; stale rdata is never presented; a new start reads the full frame from (0,0).
- COLS=1, ROWS=3 -> 3 words, each with q_eol=1, and q_last only on the third.
